branch_predictor_gshare: RTL and testbench

BRANCH_PREDICTOR_GSHARE -- requirements
Module: branch_predictor_gshare

---
 rtl/branch_predictor_gshare.sv | 170 +++++++++++++++++
 tb/tb_branch_predictor_gshare.sv | 134 +++++++++++++
 2 files changed

// File: rtl/branch_predictor_gshare.sv
// rtl/branch_predictor_gshare.sv - gshare direction predictor with direct-mapped BTB and return address stack
module branch_predictor_gshare #(
  parameter int ADDR_WIDTH  = 32,
  parameter int FETCH_WIDTH = 2,
  parameter int BTB_DEPTH   = 6,
  parameter int GHR_WIDTH   = 8,
  parameter int RAS_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           ifVld,
  input  logic [ADDR_WIDTH-1:0]          ifPC,
  input  logic                           exVld,
  input  logic [ADDR_WIDTH-1:0]          exPC,
  input  logic [ADDR_WIDTH-1:0]          exPCTar,
  input  logic [1:0]                     exType,
  input  logic                           exBranch,
  input  logic                           exWrong,
  output logic                           pdVld,
  output logic [ADDR_WIDTH-1:0]          pdPC,
  output logic                           pdBranch,
  output logic [$clog2(FETCH_WIDTH)-1:0] pdReason
);

  localparam int SW    = $clog2(FETCH_WIDTH);
  localparam int BTB_N = 1 << BTB_DEPTH;
  localparam int TAG_W = ADDR_WIDTH - BTB_DEPTH - 2;
  localparam int PHT_N = 1 << GHR_WIDTH;
  localparam int RP_W  = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RC_W  = $clog2(RAS_DEPTH + 1);

  logic                  btb_vld [BTB_N];
  logic [TAG_W-1:0]      btb_tag [BTB_N];
  logic [ADDR_WIDTH-1:0] btb_tar [BTB_N];
  logic [1:0]            btb_typ [BTB_N];
  logic [1:0]            pht     [PHT_N];
  logic [GHR_WIDTH-1:0]  ghr;
  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [RP_W-1:0]       ras_ptr;
  logic [RC_W-1:0]       ras_cnt;

  // ras_ptr is the next push slot; the top of stack sits one below it
  logic [RP_W-1:0]       ras_top_idx;
  logic [RP_W-1:0]       ras_ptr_inc;
  logic [ADDR_WIDTH-1:0] ras_top;
  assign ras_top_idx = (ras_ptr == '0) ? RP_W'(RAS_DEPTH - 1) : ras_ptr - 1'b1;
  assign ras_ptr_inc = (ras_ptr == RP_W'(RAS_DEPTH - 1)) ? '0 : ras_ptr + 1'b1;
  assign ras_top     = ras_mem[ras_top_idx];

  logic [ADDR_WIDTH-1:0]  base;
  logic [ADDR_WIDTH-1:0]  fall_pc;
  logic [FETCH_WIDTH-1:0] slot_en;
  logic [FETCH_WIDTH-1:0] slot_tk;
  logic [FETCH_WIDTH-1:0][ADDR_WIDTH-1:0] slot_tar;

  assign base    = ifPC & ~ADDR_WIDTH'((1 << (SW + 2)) - 1);
  assign fall_pc = base + ADDR_WIDTH'(4 * FETCH_WIDTH);
  assign slot_en = {FETCH_WIDTH{1'b1}} << ifPC[SW+1:2];

  for (genvar i = 0; i < FETCH_WIDTH; i++) begin : g_slot
    logic [ADDR_WIDTH-3:0] spc_w;
    logic [BTB_DEPTH-1:0]  bi;
    logic [GHR_WIDTH-1:0]  pi;
    logic                  hit;
    logic                  cond;
    assign spc_w = base[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(i);
    assign bi    = spc_w[BTB_DEPTH-1:0];
    assign pi    = spc_w[GHR_WIDTH-1:0] ^ ghr;
    assign hit   = btb_vld[bi] && (btb_tag[bi] == spc_w[ADDR_WIDTH-3:BTB_DEPTH]);
    always_comb begin
      cond = 1'b1;
      case (btb_typ[bi])
        2'b00:   cond = pht[pi][1];
        2'b11:   cond = (ras_cnt != '0);
        default: cond = 1'b1;
      endcase
    end
    assign slot_tk[i]  = slot_en[i] && hit && cond;
    assign slot_tar[i] = (btb_typ[bi] == 2'b11) ? ras_top : btb_tar[bi];
  end

  logic                  sel_br;
  logic [SW-1:0]         sel_rsn;
  logic [ADDR_WIDTH-1:0] sel_pc;

  // scan high to low so the lowest taken slot wins
  always_comb begin
    sel_br  = 1'b0;
    sel_rsn = '0;
    sel_pc  = fall_pc;
    for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
      if (slot_tk[i]) begin
        sel_br  = 1'b1;
        sel_rsn = SW'(i);
        sel_pc  = slot_tar[i];
      end
    end
  end

  logic                 btb_we, ex_cond, ras_push, ras_pop;
  logic [BTB_DEPTH-1:0] ex_bi;
  logic [GHR_WIDTH-1:0] ex_pi;
  logic [1:0]           pht_cur, pht_nxt;

  assign btb_we   = exVld && exBranch;
  assign ex_cond  = exVld && (exType == 2'b00);
  assign ras_push = exVld && exBranch && (exType == 2'b10);
  assign ras_pop  = exVld && exBranch && (exType == 2'b11) && (ras_cnt != '0);
  assign ex_bi    = exPC[BTB_DEPTH+1:2];
  assign ex_pi    = exPC[GHR_WIDTH+1:2] ^ ghr;
  assign pht_cur  = pht[ex_pi];

  always_comb begin
    pht_nxt = pht_cur;
    if (exBranch && pht_cur != 2'b11)
      pht_nxt = pht_cur + 2'b01;
    else if (!exBranch && pht_cur != 2'b00)
      pht_nxt = pht_cur - 2'b01;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BTB_N; i++) btb_vld[i] <= 1'b0;
      for (int i = 0; i < PHT_N; i++) pht[i] <= 2'b01;
      ghr     <= '0;
      ras_ptr <= '0;
      ras_cnt <= '0;
    end else begin
      if (btb_we) btb_vld[ex_bi] <= 1'b1;
      if (ex_cond) begin
        pht[ex_pi] <= pht_nxt;
        ghr        <= (ghr << 1) | GHR_WIDTH'(exBranch);
      end
      if (ras_push) begin
        ras_ptr <= ras_ptr_inc;
        if (ras_cnt != RC_W'(RAS_DEPTH)) ras_cnt <= ras_cnt + 1'b1;
      end else if (ras_pop) begin
        ras_ptr <= ras_top_idx;
        ras_cnt <= ras_cnt - 1'b1;
      end
    end
  end

  // payload arrays are qualified by btb_vld / ras_cnt, so they need no reset
  always_ff @(posedge clk) begin
    if (btb_we) begin
      btb_tag[ex_bi] <= exPC[ADDR_WIDTH-1:BTB_DEPTH+2];
      btb_tar[ex_bi] <= exPCTar;
      btb_typ[ex_bi] <= exType;
    end
    if (ras_push) ras_mem[ras_ptr] <= exPC + ADDR_WIDTH'(4);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pdVld    <= 1'b0;
      pdPC     <= '0;
      pdBranch <= 1'b0;
      pdReason <= '0;
    end else begin
      pdVld <= ifVld && !exWrong;
      if (ifVld && !exWrong) begin
        pdPC     <= sel_pc;
        pdBranch <= sel_br;
        pdReason <= sel_rsn;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// tb/tb_branch_predictor_gshare.sv - directed bench for branch_predictor_gshare
module tb_branch_predictor_gshare;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ifVld;
  logic [31:0] ifPC;
  logic        exVld;
  logic [31:0] exPC;
  logic [31:0] exPCTar;
  logic [1:0]  exType;
  logic        exBranch;
  logic        exWrong;
  logic        pdVld;
  logic [31:0] pdPC;
  logic        pdBranch;
  logic [0:0]  pdReason;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor_gshare dut (
    .clk(clk), .rstn(rstn),
    .ifVld(ifVld), .ifPC(ifPC),
    .exVld(exVld), .exPC(exPC), .exPCTar(exPCTar), .exType(exType),
    .exBranch(exBranch), .exWrong(exWrong),
    .pdVld(pdVld), .pdPC(pdPC), .pdBranch(pdBranch), .pdReason(pdReason)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_pd(input string tag, input logic v, input logic b, input logic r,
                        input logic [31:0] pc);
    chk({tag, ".vld"}, 32'(pdVld), 32'(v));
    chk({tag, ".br"},  32'(pdBranch), 32'(b));
    chk({tag, ".rsn"}, 32'(pdReason), 32'(r));
    chk({tag, ".pc"},  pdPC, pc);
  endtask

  task automatic idle();
    ifVld = 1'b0; ifPC = '0; exVld = 1'b0; exPC = '0; exPCTar = '0;
    exType = 2'b00; exBranch = 1'b0; exWrong = 1'b0;
  endtask

  task automatic pred(input logic [31:0] pc);
    idle();
    ifVld = 1'b1; ifPC = pc;
  endtask

  task automatic ex(input logic [31:0] pc, input logic [31:0] tar, input logic [1:0] typ,
                    input logic br);
    idle();
    exVld = 1'b1; exPC = pc; exPCTar = tar; exType = typ; exBranch = br;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0;
    idle();
    tick(); tick();
    chk_pd("reset", 0, 0, 0, 32'h0);
    rstn = 1'b1;

    pred(32'h1C000000); tick();
    chk_pd("cold", 1, 0, 0, 32'h1C000008);

    ex(32'h1C000104, 32'h1C000200, 2'b01, 1'b1); tick();
    chk("idle.vld", 32'(pdVld), 32'h0);
    chk("idle.pc_hold", pdPC, 32'h1C000008);
    pred(32'h1C000100); tick();
    chk_pd("jmp.hit", 1, 1, 1, 32'h1C000200);
    pred(32'h1C000108); tick();
    chk_pd("jmp.next", 1, 0, 0, 32'h1C000110);
    pred(32'h1C000104); tick();
    chk_pd("jmp.midgrp", 1, 1, 1, 32'h1C000200);

    ex(32'h1C000300, 32'h1C000800, 2'b00, 1'b1); tick();
    pred(32'h1C000300); tick();
    chk_pd("cond.ghr", 1, 0, 0, 32'h1C000308);
    ex(32'h1C000308, 32'h1C000900, 2'b00, 1'b1); tick();
    pred(32'h1C000300); tick();
    chk_pd("cond.taken", 1, 1, 0, 32'h1C000800);
    pred(32'h1C000308); tick();
    chk_pd("cond.weak", 1, 0, 0, 32'h1C000310);

    ex(32'h1C001010, 32'h1C000000, 2'b11, 1'b1); tick();
    ex(32'h1C000400, 32'h1C001000, 2'b10, 1'b1); tick();
    pred(32'h1C001010); tick();
    chk_pd("ret.ras", 1, 1, 0, 32'h1C000404);
    pred(32'h1C000404); tick();
    chk_pd("skip.slot0", 1, 0, 0, 32'h1C000408);

    ex(32'h1C000A08, 32'h1C000000, 2'b11, 1'b1); tick();
    for (int k = 0; k < 5; k++) begin
      ex(32'h1C000500 + 32'(16 * k), 32'h1C003000, 2'b10, 1'b1); tick();
    end
    for (int k = 0; k < 4; k++) begin
      ex(32'h1C000A08, 32'h1C000000, 2'b11, 1'b1);
      ifVld = 1'b1; ifPC = 32'h1C000A08;
      tick();
      chk_pd($sformatf("ras.pop%0d", k), 1, 1, 0, 32'h1C000544 - 32'(16 * k));
    end
    pred(32'h1C000A08); tick();
    chk_pd("ras.empty", 1, 0, 0, 32'h1C000A10);

    pred(32'h1C000100); tick();
    chk_pd("pre.flush", 1, 1, 1, 32'h1C000200);
    pred(32'h1C000000); exWrong = 1'b1; tick();
    chk_pd("flush", 0, 1, 1, 32'h1C000200);
    idle(); tick();
    chk_pd("no.req", 0, 1, 1, 32'h1C000200);
    #2 rstn = 1'b0;
    #1 chk_pd("async.rst", 0, 0, 0, 32'h0);
    tick();
    rstn = 1'b1;
    pred(32'h1C000100); tick();
    chk_pd("post.rst", 1, 0, 0, 32'h1C000108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
